serial_sub_ctrl: RTL

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

---
 rtl/serial_sub_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial, LSB-first subtractor (a - b) with IDLE/RUN/DONE control
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bor
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_load;
    logic w_step;
    logic w_last;
    logic w_ai;
    logic w_bi;
    logic w_d;
    logic w_br_nxt;

    // abort outranks start, so a simultaneous start+abort in IDLE is not a load
    assign w_load = (r_state == c_IDLE) && start && !abort;
    assign w_step = (r_state == c_RUN) && !abort;
    assign w_last = (r_cnt == c_LAST);

    assign w_ai     = r_a[0];
    assign w_bi     = r_b[0];
    assign w_d      = w_ai ^ w_bi ^ r_br;
    assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_load) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_RUN:   busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            diff  <= '0;
            bor   <= 1'b0;
        end else if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_br_nxt;
            // hold on the final bit so a power-of-two WIDTH never wraps
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                diff <= {w_d, r_res[WIDTH-1:1]};
                bor  <= w_br_nxt;
            end
        end
    end

endmodule

`default_nettype wire
